// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, default geometry, address helper.
package dmem_responder_pkg;

  localparam int unsigned DefaultAw  = 10;
  localparam int unsigned DefaultLat = 2;

  typedef enum logic [1:0] {
    DmemIdle = 2'd0,
    DmemBusy = 2'd1,
    DmemDone = 2'd2
  } dmem_state_e;

  // Byte address to word address; callers keep only the low AW bits so upper bits alias.
  function automatic logic [29:0] wordAddr(input logic [31:0] byteAddr);
    return byteAddr[31:2];
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-wide data RAM: asynchronous read port, one synchronous write port, contents never cleared.
module dmem_responder_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int unsigned Depth = 1 << AW;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder with programmable access latency and a stall output.
// Optional misaligned-request detection is enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW  = DefaultAw,
  parameter int unsigned LAT = DefaultLat
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        memstallM,
  output logic        misalignM
);

  logic [29:0]   wordAll;
  logic [AW-1:0] reqIdx;
  logic          req;
  logic          misalign;

  assign wordAll = wordAddr(aluoutM);
  assign reqIdx  = wordAll[AW-1:0];
  assign req     = memreadM | memwriteM;

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = req & (|aluoutM[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits alias by design; low bits only matter with the alignment check.
  logic unused_addr;
  assign unused_addr = ^{wordAll[29:AW], aluoutM[1:0]};

  logic          ramWe;
  logic [AW-1:0] ramWaddr;
  logic [AW-1:0] ramRaddr;
  logic [31:0]   ramWdata;
  logic [31:0]   ramRdata;

  dmem_responder_ram #(
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ramWe),
    .waddr(ramWaddr),
    .wdata(ramWdata),
    .raddr(ramRaddr),
    .rdata(ramRdata)
  );

  if (LAT == 0) begin : gNoLat
    assign ramRaddr  = reqIdx;
    assign ramWaddr  = reqIdx;
    assign ramWdata  = writedataM;
    assign ramWe     = memwriteM & ~misalign;
    assign readdataM = ramRdata;
    assign memstallM = 1'b0;
    assign misalignM = misalign;

    logic unused_lat0;
    assign unused_lat0 = ^{rst, req};
  end else begin : gLat
    // BUSY spans LAT-1 cycles so IDLE + BUSY account for the LAT stalled cycles.
    localparam logic [3:0] CntInit = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    dmem_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          we_q, we_d;
    logic          stall;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= DmemIdle;
        cnt_q   <= 4'd0;
        addr_q  <= '0;
        wdata_q <= 32'd0;
        rdata_q <= 32'd0;
        we_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        we_q    <= we_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      we_d     = we_q;
      stall    = 1'b0;
      ramRaddr = addr_q;
      ramWe    = 1'b0;
      unique case (state_q)
        DmemIdle: begin
          ramRaddr = reqIdx;
          stall    = req & ~misalign;
          if (req && !misalign) begin
            addr_d  = reqIdx;
            wdata_d = writedataM;
            we_d    = memwriteM;
            if (LAT == 1) begin
              state_d = DmemDone;
              rdata_d = ramRdata;
            end else begin
              state_d = DmemBusy;
              cnt_d   = CntInit;
            end
          end
        end
        DmemBusy: begin
          stall = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = DmemDone;
            rdata_d = ramRdata;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DmemDone: begin
          // A reset landing on the DONE edge aborts the store.
          ramWe   = we_q & ~rst;
          state_d = DmemIdle;
        end
        default: state_d = DmemIdle;
      endcase
    end

    assign ramWaddr  = addr_q;
    assign ramWdata  = wdata_q;
    assign readdataM = rdata_q;
    assign memstallM = stall;
    assign misalignM = misalign & (state_q == DmemIdle);
  end

endmodule
